// File: rtl/t_to_jk_flipflop_bank_pkg.sv
// Shared types and helpers for the JK-on-T flip-flop bank.
package t_to_jk_flipflop_bank_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TOG_W = 16;
    // Widest bank the popcount helper can handle.
    localparam int POP_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/t_to_jk_flipflop_bank_if.sv
// Command/status bundle for t_to_jk_flipflop_bank.
// Preset ports exist only when TFF_BANK_PRESET_EN is defined.
interface t_to_jk_flipflop_bank_if
    import t_to_jk_flipflop_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TOG_W = DEF_TOG_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_j;
    logic [WIDTH-1:0] cmd_k;
    logic [CNT_W-1:0] cmd_cycles;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [TOG_W-1:0] toggles;
`ifdef TFF_BANK_PRESET_EN
    logic             preset_valid;
    logic [WIDTH-1:0] preset_value;

    modport master (
        output cmd_valid, cmd_j, cmd_k, cmd_cycles, preset_valid, preset_value,
        input  cmd_ready, q, busy, done, toggles
    );
    modport slave (
        input  cmd_valid, cmd_j, cmd_k, cmd_cycles, preset_valid, preset_value,
        output cmd_ready, q, busy, done, toggles
    );
`else
    modport master (
        output cmd_valid, cmd_j, cmd_k, cmd_cycles,
        input  cmd_ready, q, busy, done, toggles
    );
    modport slave (
        input  cmd_valid, cmd_j, cmd_k, cmd_cycles,
        output cmd_ready, q, busy, done, toggles
    );
`endif
endinterface

// File: rtl/t_to_jk_flipflop_bank_tff_excite_cell.sv
// One T storage bit driven as a JK flip-flop: t = (j & ~q) | (k & q).
// Optional load path under TFF_BANK_PRESET_EN.
module tff_excite_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    input  logic en,
`ifdef TFF_BANK_PRESET_EN
    input  logic ld,
    input  logic d,
`endif
    output logic q,
    output logic t
);

    assign t = (j & ~q) | (k & q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
`ifdef TFF_BANK_PRESET_EN
        end else if (ld) begin
            q <= d;
`endif
        end else if (en) begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_to_jk_flipflop_bank.sv
// WIDTH-bit JK-driven T flip-flop bank: applies a JK vector for N edges,
// counts toggles (saturating), then pulses done. Optional: TFF_BANK_PRESET_EN.
module t_to_jk_flipflop_bank
    import t_to_jk_flipflop_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TOG_W = DEF_TOG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    t_to_jk_flipflop_bank_if.slave  bus
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] j_r, k_r, q, t;
    logic [CNT_W-1:0] rem;
    logic [TOG_W-1:0] toggles;
    logic [TOG_W:0]   tog_sum;
    logic             accept, apply_en, ready;

`ifdef TFF_BANK_PRESET_EN
    logic preset_ld;
    assign preset_ld = (state == IDLE) && bus.preset_valid;
    // Preset wins over a command presented in the same cycle.
    assign ready     = (state == IDLE) && !bus.preset_valid;
`else
    assign ready     = (state == IDLE);
`endif

    assign accept   = bus.cmd_valid && ready;
    assign apply_en = (state == APPLY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = APPLY;
            APPLY:   if (rem == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j_r <= '0;
            k_r <= '0;
            rem <= '0;
        end else if (accept) begin
            j_r <= bus.cmd_j;
            k_r <= bus.cmd_k;
            rem <= (bus.cmd_cycles == '0) ? CNT_W'(1) : bus.cmd_cycles;
        end else if (apply_en) begin
            rem <= rem - CNT_W'(1);
        end
    end

    // One extra bit catches the carry so the counter pins at all-ones.
    assign tog_sum = {1'b0, toggles} + (TOG_W+1)'(popcount(POP_MAX'(t)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         toggles <= '0;
        else if (accept)   toggles <= '0;
        else if (apply_en) toggles <= tog_sum[TOG_W] ? '1 : tog_sum[TOG_W-1:0];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_excite_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_r[i]),
            .k     (k_r[i]),
            .en    (apply_en),
`ifdef TFF_BANK_PRESET_EN
            .ld    (preset_ld),
            .d     (bus.preset_value[i]),
`endif
            .q     (q[i]),
            .t     (t[i])
        );
    end

    assign bus.cmd_ready = ready;
    assign bus.q         = q;
    assign bus.busy      = (state == APPLY) || (state == DONE);
    assign bus.done      = (state == DONE);
    assign bus.toggles   = toggles;

endmodule

// File: tb/tb_t_to_jk_flipflop_bank.sv
// Directed bench for t_to_jk_flipflop_bank with a result scoreboard.
module tb_t_to_jk_flipflop_bank;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 8;
    localparam int TOG_W   = 8;
    localparam int TOG_MAX = (1 << TOG_W) - 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        int               tog;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [WIDTH-1:0] mq = '0;

    t_to_jk_flipflop_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TOG_W(TOG_W)) bus ();

    t_to_jk_flipflop_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TOG_W(TOG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [WIDTH-1:0] eq, input int etog);
        chk({tag, "_q"}, 32'(bus.q), 32'(eq));
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_tog"}, 32'(bus.toggles), 32'(etog));
    endtask

    // Model the command, push the expectation, run it, compare at done.
    task automatic run_cmd(input string tag, input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k,
                           input logic [CNT_W-1:0] cyc, input bit glitch);
        int   ce, tog, n;
        bit   found;
        exp_t e;
        logic [WIDTH-1:0] tv;
        ce  = (cyc == 0) ? 1 : int'(cyc);
        tog = 0;
        for (int i = 0; i < ce; i++) begin
            tv  = (j & ~mq) | (k & mq);
            mq  = mq ^ tv;
            tog = tog + $countones(tv);
            if (tog > TOG_MAX) tog = TOG_MAX;
        end
        sb.push_back('{mq, tog});

        chk({tag, "_ready_pre"}, 32'(bus.cmd_ready), 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_j      = j;
        bus.cmd_k      = k;
        bus.cmd_cycles = cyc;
        tick();
        bus.cmd_valid  = 1'b0;
        chk({tag, "_busy_apply"}, 32'(bus.busy), 1);
        chk({tag, "_ready_apply"}, 32'(bus.cmd_ready), 0);

        found = 1'b0;
        n = 0;
        for (int c = 1; c <= 300; c++) begin
            if (glitch && c == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_j     = '1;
                bus.cmd_k     = '0;
            end else if (glitch && c == 2) begin
                bus.cmd_valid = 1'b0;
            end
            tick();
            if (bus.done) begin
                found = 1'b1;
                n = c;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!found) begin
            chk({tag, "_done_timeout"}, 0, 1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(ce));
        chk({tag, "_q"}, 32'(bus.q), 32'(e.q));
        chk({tag, "_tog"}, 32'(bus.toggles), 32'(e.tog));
        chk({tag, "_ready_done"}, 32'(bus.cmd_ready), 0);
        tick();
        chk_idle({tag, "_after"}, e.q, e.tog);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_j      = '0;
        bus.cmd_k      = '0;
        bus.cmd_cycles = '0;
`ifdef TFF_BANK_PRESET_EN
        bus.preset_valid = 1'b0;
        bus.preset_value = '0;
`endif
        #12;
        chk_idle("reset", 8'h00, 0);
        reset = 1'b0;
        tick();
        chk_idle("post_reset", 8'h00, 0);

        run_cmd("set",        8'hFF, 8'h00, 8'd1, 1'b0);
        run_cmd("tog_odd",    8'h0F, 8'h0F, 8'd3, 1'b0);
        run_cmd("tog_even",   8'h0F, 8'h0F, 8'd2, 1'b0);
        run_cmd("clear",      8'h00, 8'hFF, 8'd1, 1'b0);
        run_cmd("zero_cnt",   8'h01, 8'h00, 8'd0, 1'b0);
        run_cmd("busy_ignore",8'h00, 8'h00, 8'd3, 1'b1);

        // Reset part-way through a long toggle run.
        bus.cmd_valid  = 1'b1;
        bus.cmd_j      = 8'hFF;
        bus.cmd_k      = 8'hFF;
        bus.cmd_cycles = 8'd10;
        tick();
        bus.cmd_valid  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midop_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk_idle("midop_reset", 8'h00, 0);
        #2;
        reset = 1'b0;
        mq = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midop_no_done", 32'(bus.done), 0);
        end
        chk_idle("midop_settled", 8'h00, 0);

        run_cmd("saturate",   8'hFF, 8'hFF, 8'd40, 1'b0);
        run_cmd("tog_clear",  8'hFF, 8'h00, 8'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
